// File: rtl/alu_ctl_pkg.sv
// Shared constants, types and the latency-to-counter-width helper for the
// sequenced ALU control unit (alu_control_seq).
package alu_ctl_pkg;

   // ALU control codes presented to the datapath
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b1001;
   localparam logic [3:0] ALU_SRL  = 4'b1010;
   localparam logic [3:0] ALU_SRA  = 4'b1011;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_MULT = 4'b1101;
   localparam logic [3:0] ALU_DIV  = 4'b1110;

   localparam logic [1:0] AOP_MEM   = 2'b00;
   localparam logic [1:0] AOP_BEQ   = 2'b01;
   localparam logic [1:0] AOP_RTYPE = 2'b10;

   localparam logic [5:0] F_SLL   = 6'b000000;
   localparam logic [5:0] F_SRL   = 6'b000010;
   localparam logic [5:0] F_SRA   = 6'b000011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_ADDU  = 6'b100001;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_SUBU  = 6'b100011;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_XOR   = 6'b100110;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_SLTU  = 6'b101011;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   typedef struct packed {
      logic [3:0] code;
      logic       is_md;
      logic       is_div;
      logic       illegal;
   } dec_t;

   // Counter must hold LAT-1; never narrower than one bit.
   function automatic int lat_to_cnt_w(input int lat);
      return (lat <= 2) ? 1 : $clog2(lat);
   endfunction

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational (alu_op, funct) -> {code, is_md, is_div, illegal} map.
// ALU_CTL_DIV_EN enables DIV/DIVU; without it they decode as illegal.
module alu_ctl_decode
   import alu_ctl_pkg::*;
(
   input  logic [1:0] alu_op_i,
   input  logic [5:0] funct_i,
   output dec_t       dec_o
);

   always_comb begin
      // NOTE: defaults assigned first so every path drives every field and no latch is inferred.
      dec_o = '0;
      unique case (alu_op_i)
         AOP_MEM: dec_o.code = ALU_ADD;
         AOP_BEQ: dec_o.code = ALU_SUB;
         AOP_RTYPE: begin
            unique case (funct_i)
               F_ADD, F_ADDU: dec_o.code = ALU_ADD;
               F_SUB, F_SUBU: dec_o.code = ALU_SUB;
               F_AND:         dec_o.code = ALU_AND;
               F_OR:          dec_o.code = ALU_OR;
               F_XOR:         dec_o.code = ALU_XOR;
               F_NOR:         dec_o.code = ALU_NOR;
               F_SLT:         dec_o.code = ALU_SLT;
               F_SLTU:        dec_o.code = ALU_SLTU;
               F_SLL:         dec_o.code = ALU_SLL;
               F_SRL:         dec_o.code = ALU_SRL;
               F_SRA:         dec_o.code = ALU_SRA;
               F_MULT, F_MULTU: begin
                  dec_o.code  = ALU_MULT;
                  dec_o.is_md = 1'b1;
               end
`ifdef ALU_CTL_DIV_EN
               F_DIV, F_DIVU: begin
                  dec_o.code   = ALU_DIV;
                  dec_o.is_md  = 1'b1;
                  dec_o.is_div = 1'b1;
               end
`endif
               default: dec_o.illegal = 1'b1;
            endcase
         end
         default: dec_o.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_control_seq.sv
// Sequenced ALU control unit: valid/ready decode handshake, multiply/divide
// latency FSM and registered outputs. ALU_CTL_DIV_EN enables DIV/DIVU sequencing.
module alu_control_seq
   import alu_ctl_pkg::*;
#(
   parameter int CTRL_W   = 4,
   parameter int MULT_LAT = 4,
   parameter int DIV_LAT  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        alu_op,
   input  logic [5:0]        funct,
   output logic              out_valid,
   output logic [CTRL_W-1:0] alu_ctl,
   output logic              illegal,
   output logic              md_start,
   output logic              hilo_we,
   output logic              stall
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CNT_W   = lat_to_cnt_w(MAX_LAT);
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
`ifdef ALU_CTL_DIV_EN
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);
`endif

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       ctl_q, ctl_d;
   logic             ill_q, ill_d;
   logic             sc_vld_q, sc_vld_d;
   logic             start_q, start_d;

   dec_t             dec;
   logic             done;
   logic             accept;
   logic             md_acc;
   logic [CNT_W-1:0] load_val;

   alu_ctl_decode u_decode (
      .alu_op_i (alu_op),
      .funct_i  (funct),
      .dec_o    (dec)
   );

   // Completion cycle of a multiply/divide; a new request may enter here.
   assign done     = (state_q == ST_BUSY) && (cnt_q == '0);
   assign in_ready = (state_q == ST_IDLE) || done;
   assign accept   = in_valid && in_ready;

`ifdef ALU_CTL_DIV_EN
   assign md_acc   = accept && dec.is_md;
   assign load_val = dec.is_div ? DIV_LOAD : MULT_LOAD;
`else
   // Divide never starts when its sequencing is compiled out.
   assign md_acc   = accept && dec.is_md && !dec.is_div;
   assign load_val = MULT_LOAD;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ctl_d    = ctl_q;
      ill_d    = ill_q;
      sc_vld_d = 1'b0;
      start_d  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (md_acc) begin
               state_d = ST_BUSY;
               cnt_d   = load_val;
            end
         end
         ST_BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (md_acc) begin
               cnt_d = load_val;
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase

      if (accept) begin
         ctl_d    = dec.code;
         ill_d    = dec.illegal;
         start_d  = md_acc;
         sc_vld_d = !md_acc;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         ctl_q    <= '0;
         ill_q    <= 1'b0;
         sc_vld_q <= 1'b0;
         start_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ctl_q    <= ctl_d;
         ill_q    <= ill_d;
         sc_vld_q <= sc_vld_d;
         start_q  <= start_d;
      end
   end

   assign out_valid = sc_vld_q || done;
   assign hilo_we   = done;
   assign stall     = (state_q == ST_BUSY) && (cnt_q != '0);
   assign md_start  = start_q;
   assign illegal   = ill_q && sc_vld_q;
   assign alu_ctl   = CTRL_W'(ctl_q);

endmodule

// File: tb/tb_alu_control_seq.sv
// Bench for alu_control_seq: two instances (long and unit multiply latency),
// directed scenarios plus randomized traffic checked against a timeline model.
module tb_alu_control_seq;

   localparam int M0 = 4;
   localparam int D0 = 32;
   localparam int M1 = 1;
   localparam int D1 = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       iv  [2];
   logic [1:0] op  [2];
   logic [5:0] fn  [2];
   logic       rdy [2];
   logic       ov  [2];
   logic       ill [2];
   logic       mds [2];
   logic       hw  [2];
   logic       stl [2];
   logic [3:0] ctl0;
   logic [5:0] ctl1;
   logic [5:0] ctl_x [2];

   assign ctl_x[0] = {2'b00, ctl0};
   assign ctl_x[1] = ctl1;

   always #5 clk = ~clk;

   alu_control_seq #(.CTRL_W(4), .MULT_LAT(M0), .DIV_LAT(D0)) u0 (
      .clk(clk), .reset(rst), .in_valid(iv[0]), .in_ready(rdy[0]),
      .alu_op(op[0]), .funct(fn[0]), .out_valid(ov[0]), .alu_ctl(ctl0),
      .illegal(ill[0]), .md_start(mds[0]), .hilo_we(hw[0]), .stall(stl[0])
   );

   alu_control_seq #(.CTRL_W(6), .MULT_LAT(M1), .DIV_LAT(D1)) u1 (
      .clk(clk), .reset(rst), .in_valid(iv[1]), .in_ready(rdy[1]),
      .alu_op(op[1]), .funct(fn[1]), .out_valid(ov[1]), .alu_ctl(ctl1),
      .illegal(ill[1]), .md_start(mds[1]), .hilo_we(hw[1]), .stall(stl[1])
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int u, input logic [5:0] got, input logic [5:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s u%0d cyc=%0d got=%0h expected=%0h", name, u, cyc, got, exp);
      end
   endtask

   task automatic check_bit(input string name, input int u, input logic got, input logic exp);
      check(name, u, {5'b0, got}, {5'b0, exp});
   endtask

   // Reference decode table: funct -> ALU code, -1 for unsupported.
   int rtab [64];
   initial begin
      for (int i = 0; i < 64; i++) rtab[i] = -1;
      rtab[6'b100000] = 2;  rtab[6'b100001] = 2;
      rtab[6'b100010] = 6;  rtab[6'b100011] = 6;
      rtab[6'b100100] = 0;  rtab[6'b100101] = 1;
      rtab[6'b100110] = 3;  rtab[6'b100111] = 12;
      rtab[6'b101010] = 7;  rtab[6'b101011] = 8;
      rtab[6'b000000] = 9;  rtab[6'b000010] = 10;
      rtab[6'b000011] = 11;
      rtab[6'b011000] = 13; rtab[6'b011001] = 13;
`ifdef ALU_CTL_DIV_EN
      rtab[6'b011010] = 14; rtab[6'b011011] = 14;
`endif
   end

   // Expected-output timeline, indexed by absolute cycle modulo 64.
   bit         e_ov   [2][64];
   bit         e_st   [2][64];
   bit         e_hw   [2][64];
   bit         e_stl  [2][64];
   bit         e_ctlv [2][64];
   bit         e_illv [2][64];
   bit         e_ill  [2][64];
   logic [5:0] e_ctl  [2][64];
   int         ready_at [2] = '{0, 0};
   bit         acc      [2];

   int         m_s, m_t, m_code, m_lat, m_mlat, m_dlat;
   bit         m_ill;

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         m_s = cyc % 64;
         check_bit("in_ready", i, rdy[i], cyc >= ready_at[i]);
         check_bit("out_valid", i, ov[i], e_ov[i][m_s]);
         check_bit("md_start", i, mds[i], e_st[i][m_s]);
         check_bit("hilo_we", i, hw[i], e_hw[i][m_s]);
         check_bit("stall", i, stl[i], e_stl[i][m_s]);
         if (e_ctlv[i][m_s]) check("alu_ctl", i, ctl_x[i], e_ctl[i][m_s]);
         if (e_illv[i][m_s]) check_bit("illegal", i, ill[i], e_ill[i][m_s]);
         e_ov[i][m_s] = 0; e_st[i][m_s] = 0; e_hw[i][m_s] = 0; e_stl[i][m_s] = 0;
         e_ctlv[i][m_s] = 0; e_illv[i][m_s] = 0;

         acc[i] = 1'b0;
         if (rst) begin
            for (int j = 0; j < 64; j++) begin
               e_ov[i][j] = 0; e_st[i][j] = 0; e_hw[i][j] = 0; e_stl[i][j] = 0;
               e_ctlv[i][j] = 0; e_illv[i][j] = 0;
            end
            ready_at[i] = cyc + 1;
            m_t = (cyc + 1) % 64;
            e_ctlv[i][m_t] = 1; e_ctl[i][m_t] = 6'd0;
            e_illv[i][m_t] = 1; e_ill[i][m_t] = 0;
         end else if (iv[i] && cyc >= ready_at[i]) begin
            acc[i]  = 1'b1;
            m_mlat  = (i == 0) ? M0 : M1;
            m_dlat  = (i == 0) ? D0 : D1;
            m_code  = 0;
            m_ill   = 0;
            m_lat   = 0;
            if (op[i] == 2'b00) m_code = 2;
            else if (op[i] == 2'b01) m_code = 6;
            else if (op[i] == 2'b11) m_ill = 1;
            else if (rtab[fn[i]] < 0) m_ill = 1;
            else m_code = rtab[fn[i]];
            if (m_code == 13) m_lat = m_mlat;
            if (m_code == 14) m_lat = m_dlat;
            if (m_lat == 0) begin
               m_t = (cyc + 1) % 64;
               e_ov[i][m_t] = 1;
               e_ctlv[i][m_t] = 1; e_ctl[i][m_t] = 6'(m_code);
               e_illv[i][m_t] = 1; e_ill[i][m_t] = m_ill;
            end else begin
               for (int j = 1; j <= m_lat; j++) begin
                  m_t = (cyc + j) % 64;
                  e_ctlv[i][m_t] = 1; e_ctl[i][m_t] = 6'(m_code);
                  if (j < m_lat) e_stl[i][m_t] = 1;
               end
               e_st[i][(cyc + 1) % 64] = 1;
               m_t = (cyc + m_lat) % 64;
               e_ov[i][m_t] = 1; e_hw[i][m_t] = 1;
               e_illv[i][m_t] = 1; e_ill[i][m_t] = 0;
               ready_at[i] = cyc + m_lat;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int u, input logic v, input logic [1:0] a, input logic [5:0] f);
      iv[u] = v;
      op[u] = a;
      fn[u] = f;
   endtask

   logic [5:0] seq_f [5]    = '{6'b100000, 6'b100010, 6'b100110, 6'b000011, 6'b101010};
   logic [5:0] seq_c [5]    = '{6'b000010, 6'b000110, 6'b000011, 6'b001011, 6'b000111};
   logic [5:0] legal_f [17] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                                6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011,
                                6'b000000, 6'b000010, 6'b000011, 6'b011000, 6'b011001,
                                6'b011010, 6'b011011};
   logic       hilo_seen;
   int         rst_at;
   logic [5:0] rst_f;

   initial begin
      rst = 1'b1;
      drive(0, 0, 2'b00, 6'd0);
      drive(1, 0, 2'b00, 6'd0);
      repeat (2) tick();
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      check_bit("rst_in_ready", 0, rdy[0], 1'b1);
      check_bit("rst_out_valid", 0, ov[0], 1'b0);
      check("rst_alu_ctl", 0, ctl_x[0], 6'd0);
      check_bit("rst_illegal", 0, ill[0], 1'b0);
      check_bit("rst_md_start", 0, mds[0], 1'b0);
      check_bit("rst_hilo_we", 0, hw[0], 1'b0);
      check_bit("rst_stall", 0, stl[0], 1'b0);
      check_bit("rst_in_ready", 1, rdy[1], 1'b1);
      tick();

      // add, sub, xor, sra, slt back to back
      drive(0, 1, 2'b10, seq_f[0]);
      for (int j = 0; j < 5; j++) begin
         tick();
         if (j < 4) drive(0, 1, 2'b10, seq_f[j+1]);
         else drive(0, 0, 2'b00, 6'd0);
         @(negedge clk);
         check_bit("seq_valid", 0, ov[0], 1'b1);
         check("seq_ctl", 0, ctl_x[0], seq_c[j]);
      end

      // Unsupported funct
      tick();
      drive(0, 1, 2'b10, 6'b111111);
      tick();
      drive(0, 0, 2'b00, 6'd0);
      @(negedge clk);
      check_bit("ill_valid", 0, ov[0], 1'b1);
      check("ill_ctl", 0, ctl_x[0], 6'd0);
      check_bit("ill_flag", 0, ill[0], 1'b1);

      // MULT with a held add behind it
      tick();
      drive(0, 1, 2'b10, 6'b011000);
      tick();
      drive(0, 1, 2'b10, 6'b100000);
      @(negedge clk);
      check_bit("mult_start", 0, mds[0], 1'b1);
      check_bit("mult_stall1", 0, stl[0], 1'b1);
      check_bit("mult_ready1", 0, rdy[0], 1'b0);
      tick();
      @(negedge clk);
      check_bit("mult_stall2", 0, stl[0], 1'b1);
      check_bit("mult_start2", 0, mds[0], 1'b0);
      tick();
      @(negedge clk);
      check_bit("mult_stall3", 0, stl[0], 1'b1);
      tick();
      @(negedge clk);
      check_bit("mult_done_valid", 0, ov[0], 1'b1);
      check_bit("mult_done_hilo", 0, hw[0], 1'b1);
      check_bit("mult_done_ready", 0, rdy[0], 1'b1);
      check_bit("mult_done_stall", 0, stl[0], 1'b0);
      check("mult_done_ctl", 0, ctl_x[0], 6'b001101);
      tick();
      drive(0, 0, 2'b00, 6'd0);
      @(negedge clk);
      check_bit("held_add_valid", 0, ov[0], 1'b1);
      check("held_add_ctl", 0, ctl_x[0], 6'b000010);
      check_bit("held_add_hilo", 0, hw[0], 1'b0);

      // DIV
      tick();
      drive(0, 1, 2'b10, 6'b011010);
      tick();
      drive(0, 0, 2'b00, 6'd0);
      @(negedge clk);
`ifdef ALU_CTL_DIV_EN
      check_bit("div_start", 0, mds[0], 1'b1);
      repeat (30) tick();
      @(negedge clk);
      check_bit("div_c31_hilo", 0, hw[0], 1'b0);
      check_bit("div_c31_stall", 0, stl[0], 1'b1);
      tick();
      @(negedge clk);
      check_bit("div_c32_hilo", 0, hw[0], 1'b1);
      check_bit("div_c32_valid", 0, ov[0], 1'b1);
      check("div_c32_ctl", 0, ctl_x[0], 6'b001110);
      rst_at = 10;
      rst_f  = 6'b011010;
`else
      check_bit("div_ill_valid", 0, ov[0], 1'b1);
      check_bit("div_ill_flag", 0, ill[0], 1'b1);
      check_bit("div_no_start", 0, mds[0], 1'b0);
      check("div_ill_ctl", 0, ctl_x[0], 6'd0);
      rst_at = 2;
      rst_f  = 6'b011000;
`endif

      // Reset in the middle of a multi-cycle operation
      tick();
      drive(0, 1, 2'b10, rst_f);
      tick();
      drive(0, 0, 2'b00, 6'd0);
      repeat (rst_at - 1) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_bit("abort_valid", 0, ov[0], 1'b0);
      check_bit("abort_hilo", 0, hw[0], 1'b0);
      check_bit("abort_stall", 0, stl[0], 1'b0);
      check_bit("abort_start", 0, mds[0], 1'b0);
      check_bit("abort_ready", 0, rdy[0], 1'b1);
      hilo_seen = 1'b0;
      repeat (40) begin
         tick();
         @(negedge clk);
         if (hw[0]) hilo_seen = 1'b1;
      end
      check_bit("abort_no_hilo", 0, hilo_seen, 1'b0);

      // Unit multiply latency, back to back
      tick();
      drive(1, 1, 2'b10, 6'b011001);
      tick();
      drive(1, 1, 2'b10, 6'b011000);
      @(negedge clk);
      check_bit("lat1_start", 1, mds[1], 1'b1);
      check_bit("lat1_valid", 1, ov[1], 1'b1);
      check_bit("lat1_hilo", 1, hw[1], 1'b1);
      check_bit("lat1_stall", 1, stl[1], 1'b0);
      check_bit("lat1_ready", 1, rdy[1], 1'b1);
      tick();
      drive(1, 0, 2'b00, 6'd0);
      @(negedge clk);
      check_bit("lat1_b2b_start", 1, mds[1], 1'b1);
      check_bit("lat1_b2b_hilo", 1, hw[1], 1'b1);
      check("lat1_b2b_ctl", 1, ctl_x[1], 6'b001101);
      tick();
      @(negedge clk);
      check_bit("lat1_idle_valid", 1, ov[1], 1'b0);

      // Randomized traffic on both instances
      repeat (3000) begin
         tick();
         rst = ($urandom_range(0, 299) == 0);
         for (int u = 0; u < 2; u++) begin
            if (!(iv[u] && !acc[u])) begin
               iv[u] = ($urandom_range(0, 3) != 0);
               case ($urandom_range(0, 9))
                  0:       op[u] = 2'b00;
                  1:       op[u] = 2'b01;
                  2:       op[u] = 2'b11;
                  default: op[u] = 2'b10;
               endcase
               if ($urandom_range(0, 9) == 0) fn[u] = 6'($urandom_range(0, 63));
               else fn[u] = legal_f[$urandom_range(0, 16)];
            end
         end
      end
      tick();
      rst = 1'b0;
      drive(0, 0, 2'b00, 6'd0);
      drive(1, 0, 2'b00, 6'd0);
      repeat (40) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
